// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 8-bit ALU.
// Define ALU_ARB_PERF_EN to add saturating per-requester grant counters.
module alu8 #(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         c,
  output logic         v
);

  logic [W:0] s;

  always_comb begin
    s = '0;
    y = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      3'b001: begin
        // bit W of the difference is the borrow; carry out is its inverse
        s = {1'b0, a} - {1'b0, b};
        y = s[W-1:0];
        c = ~s[W];
        v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      3'b010: begin
        s = {1'b0, a} + {{W{1'b0}}, 1'b1};
        y = s[W-1:0];
        c = s[W];
        v = ~a[W-1] & y[W-1];
      end
      3'b011: y = a;
      3'b100: y = a & b;
      3'b101: y = a | b;
      3'b110: y = a ^ b;
      3'b111: y = ~a;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter bit RR_INIT = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              rsp_neg,
  output logic              rsp_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

  if (DATA_W != 8) begin : g_width_chk
    $error("alu_arbiter: DATA_W must be 8");
  end
  if (CNT_W < 1) begin : g_cnt_chk
    $error("alu_arbiter: CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic              id;
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

  state_t            state;
  logic              prio;
  op_t               cur;
  logic              gnt0;
  logic              gnt1;
  logic [DATA_W-1:0] y;
  logic              c;
  logic              v;

  assign gnt0 = req0_valid && (!req1_valid || !prio);
  assign gnt1 = req1_valid && (!req0_valid || prio);

  assign req0_ready = (state == IDLE) && gnt0;
  assign req1_ready = (state == IDLE) && gnt1;

  alu8 #(
    .W (DATA_W)
  ) u_alu (
    .op (cur.op),
    .a  (cur.a),
    .b  (cur.b),
    .y  (y),
    .c  (c),
    .v  (v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= RR_INIT;
      cur       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_neg   <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            cur   <= gnt1 ? {1'b1, req1_op, req1_a, req1_b}
                          : {1'b0, req0_op, req0_a, req0_b};
            prio  <= gnt0;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= y;
          rsp_cout  <= c;
          rsp_ovf   <= v;
          rsp_neg   <= y[DATA_W-1];
          rsp_zero  <= (y == '0);
          rsp_id    <= cur.id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && gnt_cnt0 != '1)
        gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (req1_ready && gnt_cnt1 != '1)
        gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration, ALU results,
// backpressure, async reset and optional grant counters.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_cout, rsp_ovf, rsp_neg, rsp_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
  logic        s_r0, s_r1, s_rv, s_id, s_c, s_v, s_n, s_z;
  logic [7:0]  s_d;
  logic [1:0]  s_cnt0, s_cnt1;
`endif

  alu_arbiter #(
    .DATA_W  (8),
    .RR_INIT (1'b0),
    .CNT_W   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .rsp_neg    (rsp_neg),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_PERF_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
`endif
  );

`ifdef ALU_ARB_PERF_EN
  alu_arbiter #(
    .DATA_W  (8),
    .RR_INIT (1'b0),
    .CNT_W   (2)
  ) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (s_r0),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (s_r1),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (s_rv),
    .rsp_ready  (rsp_ready),
    .rsp_id     (s_id),
    .rsp_data   (s_d),
    .rsp_cout   (s_c),
    .rsp_ovf    (s_v),
    .rsp_neg    (s_n),
    .rsp_zero   (s_z),
    .gnt_cnt0   (s_cnt0),
    .gnt_cnt1   (s_cnt1)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {id, z, n, v, c, data}
  function automatic logic [12:0] rsp_pk();
    return {rsp_id, rsp_zero, rsp_neg, rsp_ovf, rsp_cout, rsp_data};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input bit id, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        output logic [12:0] r);
    bit ok;
    ok = 1'b0;
    r  = '0;
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", 32'(ok), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_wait", 32'(ok), 32'd1);
    r = rsp_pk();
  endtask

  logic [2:0]  v_op [9] = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd7,
                            3'd1, 3'd1, 3'd0, 3'd6};
  logic [7:0]  v_a  [9] = '{8'hFF, 8'hFF, 8'h80, 8'h0F, 8'h0F,
                            8'h05, 8'h80, 8'h80, 8'hC3};
  logic [7:0]  v_b  [9] = '{8'h01, 8'h07, 8'hFF, 8'h30, 8'h00,
                            8'h03, 8'h01, 8'h80, 8'h3C};
  logic [11:0] v_e  [9] = '{12'h900, 12'h900, 12'h480, 12'h03F, 12'h4F0,
                            12'h102, 12'h37F, 12'hB00, 12'h4FF};

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [12:0] r;
    bit ok;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp", 32'(rsp_pk()), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    rst_n = 1'b1;

    // 1: single ADD, latency
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'd100; req0_b = 8'd27;
    rsp_ready = 1'b1;
    #1;
    chk("t1_rdy", 32'({req0_ready, req1_ready}), 32'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("t1_lat", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp", 32'(rsp_pk()), 32'h007F);

    // 2: simultaneous requests after reset
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 8'd127; req0_b = 8'd0;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'd0; req1_b = 8'd1;
    #1;
    chk("t2_rdy_a", 32'({req0_ready, req1_ready}), 32'b10);
    @(negedge clk);
    chk("t2_busy_x", 32'({req0_ready, req1_ready}), 32'b00);
    @(negedge clk);
    chk("t2_busy_r", 32'({req0_ready, req1_ready}), 32'b00);
    chk("t2_rsp0", 32'(rsp_pk()), 32'h0680);
    @(negedge clk);
    #1;
    chk("t2_rdy_b", 32'({req0_ready, req1_ready}), 32'b01);
    req0_valid = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("t2_rsp1", 32'(rsp_pk()), 32'h14FF);

    // 3: both requesters saturated, grants alternate
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'd1; req0_b = 8'd1;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'd2; req1_b = 8'd2;
    for (int k = 0; k < 6; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        #1;
        if (req0_ready || req1_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("t3_found", 32'(ok), 32'd1);
      chk("t3_one", 32'(int'(req0_ready) + int'(req1_ready)), 32'd1);
      chk("t3_gnt", 32'(req1_ready), 32'(k % 2));
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        if (rsp_valid) break;
        @(negedge clk);
      end
      chk("t3_id", 32'({rsp_valid, rsp_id}), 32'({1'b1, k[0]}));
      if (k == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
    end

    // 4: backpressure holds the response
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'hF0; req0_b = 8'h0F;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'd3; req1_b = 8'd4;
    #1;
    chk("t4_rdy", 32'({req0_ready, req1_ready}), 32'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_v", 32'(rsp_valid), 32'd1);
      chk("t4_hold", 32'(rsp_pk()), 32'h0800);
      chk("t4_no_acc", 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t4_rdy1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("t4_rsp1", 32'(rsp_pk()), 32'h1007);

    // 5: reset during EXEC discards the op
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'd1; req0_b = 8'd2;
    #1;
    chk("t5_rdy", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_v", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_op(1'b1, 3'd6, 8'hAA, 8'hFF, r);
    chk("t5_first", 32'(r), 32'h1055);

    // reset while a response is stalled drops it asynchronously
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'd9; req0_b = 8'd9;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t5_stall", 32'(rsp_pk()), 32'h0012);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_v", 32'(rsp_valid), 32'd0);
    chk("t5_async_d", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU corner vectors, alternating requesters
    for (int i = 0; i < 9; i++) begin
      run_op(i[0], v_op[i], v_a[i], v_b[i], r);
      chk($sformatf("vec%0d", i), 32'(r), 32'({i[0], v_e[i]}));
    end

`ifdef ALU_ARB_PERF_EN
    do_reset();
    chk("p_rst", 32'({gnt_cnt0, gnt_cnt1}), 32'd0);
    for (int i = 0; i < 3; i++) run_op(1'b0, 3'd3, 8'd1, 8'd0, r);
    for (int i = 0; i < 2; i++) run_op(1'b1, 3'd3, 8'd1, 8'd0, r);
    chk("p_cnt0", 32'(gnt_cnt0), 32'd3);
    chk("p_cnt1", 32'(gnt_cnt1), 32'd2);
    chk("p_s_cnt1", 32'(s_cnt1), 32'd2);
    for (int i = 0; i < 2; i++) run_op(1'b0, 3'd3, 8'd1, 8'd0, r);
    chk("p_cnt0b", 32'(gnt_cnt0), 32'd5);
    chk("p_sat", 32'(s_cnt0), 32'd3);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
